chorus_delay_line: RTL and testbench

//  Multi-voice audio delay line for the chorus effect path. Each accepted input sample is written into an

---
 rtl/chorus_delay_line.sv | 177 +++++++++++++++++
 tb/tb_chorus_delay_line.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/chorus_delay_line.sv
// Multi-voice chorus delay line: circular sample buffer, NUM_VOICES programmable taps, averaged output.
// Optional CHORUS_DRY_MIX_EN: output becomes a 50/50 mix of the dry input and the averaged taps.
module chorus_delay_line #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int NUM_VOICES = 4
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           in_valid,
    input  logic signed [DATA_W-1:0]       in_sample,
    output logic                           in_ready,
    input  logic [NUM_VOICES*ADDR_W-1:0]   delay_bus,
    output logic                           out_valid,
    output logic signed [DATA_W-1:0]       out_sample,
    output logic                           overrun
);

    localparam int VOICE_LOG2 = $clog2(NUM_VOICES);
    localparam int ACC_W      = DATA_W + VOICE_LOG2;
    localparam int CNT_W      = (VOICE_LOG2 > 0) ? VOICE_LOG2 : 1;
    localparam logic [ADDR_W-1:0] FILL_MAX = '1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(NUM_VOICES - 1);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

    state_t                     state_q, state_d;
    logic                       init_q;
    logic [ADDR_W-1:0]          wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]          fill_q, fill_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic                       out_valid_q, out_valid_d;
    logic signed [DATA_W-1:0]   out_sample_q, out_sample_d;
    logic                       overrun_q, overrun_d;
    logic                       rd_vld_p1_q, rd_vld_p1_d;
    logic                       rd_gate_p1_q, rd_gate_p1_d;
    logic signed [DATA_W-1:0]   rd_data_p1_q;
    logic [NUM_VOICES*ADDR_W-1:0] delay_snap_q, delay_snap_d;
`ifdef CHORUS_DRY_MIX_EN
    logic signed [DATA_W-1:0]   in_snap_q, in_snap_d;
`endif

    logic [DATA_W-1:0]          mem [0:(2**ADDR_W)-1];
    logic                       mem_we;
    logic                       accept;
    logic [ADDR_W-1:0]          cur_delay;
    logic [ADDR_W-1:0]          rd_addr;
    logic signed [ACC_W-1:0]    term;
    logic signed [ACC_W-1:0]    acc_sum;

    // Mean of the taps: arithmetic shift, so truncation goes toward -inf.
    function automatic logic signed [DATA_W-1:0] wet_of(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] s;
        s = a >>> VOICE_LOG2;
        return s[DATA_W-1:0];
    endfunction

`ifdef CHORUS_DRY_MIX_EN
    function automatic logic signed [DATA_W-1:0] mix_of(input logic signed [DATA_W-1:0] dry,
                                                        input logic signed [DATA_W-1:0] wet);
        logic signed [DATA_W:0] s;
        s = {dry[DATA_W-1], dry} + {wet[DATA_W-1], wet};
        s = s >>> 1;
        return s[DATA_W-1:0];
    endfunction
`endif

    assign in_ready   = init_q && (state_q == S_IDLE);
    assign accept     = in_ready && in_valid;
    assign out_valid  = out_valid_q;
    assign out_sample = out_sample_q;
    assign overrun    = overrun_q;

    assign cur_delay = delay_snap_q[cnt_q*ADDR_W +: ADDR_W];
    assign rd_addr   = wr_ptr_q - cur_delay;
    assign term      = (rd_vld_p1_q && rd_gate_p1_q) ? ACC_W'(rd_data_p1_q) : '0;
    assign acc_sum   = acc_q + term;

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        fill_d       = fill_q;
        cnt_d        = cnt_q;
        acc_d        = acc_sum;
        out_valid_d  = 1'b0;
        out_sample_d = out_sample_q;
        overrun_d    = overrun_q | (in_valid & ~in_ready);
        rd_vld_p1_d  = 1'b0;
        rd_gate_p1_d = 1'b0;
        delay_snap_d = delay_snap_q;
        mem_we       = 1'b0;
`ifdef CHORUS_DRY_MIX_EN
        in_snap_d    = in_snap_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    mem_we       = 1'b1;
                    delay_snap_d = delay_bus;
`ifdef CHORUS_DRY_MIX_EN
                    in_snap_d    = in_sample;
`endif
                    cnt_d        = '0;
                    state_d      = S_READ;
                end
            end
            S_READ: begin
                // Taps reaching further back than the written history read as silence.
                rd_vld_p1_d  = 1'b1;
                rd_gate_p1_d = (cur_delay <= fill_q);
                cnt_d        = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Last tap folds straight into the output so out_valid lands in DONE.
                out_valid_d  = 1'b1;
`ifdef CHORUS_DRY_MIX_EN
                out_sample_d = mix_of(in_snap_q, wet_of(acc_sum));
`else
                out_sample_d = wet_of(acc_sum);
`endif
                state_d      = S_DONE;
            end
            S_DONE: begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                fill_d   = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;
                acc_d    = '0;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            init_q       <= 1'b0;
            wr_ptr_q     <= '0;
            fill_q       <= '0;
            cnt_q        <= '0;
            acc_q        <= '0;
            out_valid_q  <= 1'b0;
            out_sample_q <= '0;
            overrun_q    <= 1'b0;
            rd_vld_p1_q  <= 1'b0;
            rd_gate_p1_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            init_q       <= 1'b1;
            wr_ptr_q     <= wr_ptr_d;
            fill_q       <= fill_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            out_valid_q  <= out_valid_d;
            out_sample_q <= out_sample_d;
            overrun_q    <= overrun_d;
            rd_vld_p1_q  <= rd_vld_p1_d;
            rd_gate_p1_q <= rd_gate_p1_d;
        end
    end

    // Read stage boundary: RAM word returns one cycle after its address.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr_q] <= in_sample;
        end
        rd_data_p1_q <= mem[rd_addr];
        delay_snap_q <= delay_snap_d;
`ifdef CHORUS_DRY_MIX_EN
        in_snap_q    <= in_snap_d;
`endif
    end

endmodule

// File: tb/tb_chorus_delay_line.sv
// Directed bench for chorus_delay_line: a default instance plus a 16-deep (ADDR_W=4) instance on shared stimulus.
module tb_chorus_delay_line;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_sample = '0;
    logic [63:0] delay_bus = '0;
    logic [15:0] delay_bus4 = '0;
    logic        in_ready, out_valid, overrun;
    logic [15:0] out_sample;
    logic        in_ready4, out_valid4, overrun4;
    logic [15:0] out_sample4;

    int n_vec = 0;
    int n_err = 0;

    chorus_delay_line #(.DATA_W(16), .ADDR_W(16), .NUM_VOICES(4)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_sample(in_sample),
        .in_ready(in_ready), .delay_bus(delay_bus), .out_valid(out_valid),
        .out_sample(out_sample), .overrun(overrun)
    );

    chorus_delay_line #(.DATA_W(16), .ADDR_W(4), .NUM_VOICES(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_sample(in_sample),
        .in_ready(in_ready4), .delay_bus(delay_bus4), .out_valid(out_valid4),
        .out_sample(out_sample4), .overrun(overrun4)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mix(input logic [15:0] dry, input logic [15:0] wet);
`ifdef CHORUS_DRY_MIX_EN
        logic [16:0] s;
        s = {dry[15], dry} + {wet[15], wet};
        return s[16:1];
`else
        return wet;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_delays(input int d0, input int d1, input int d2, input int d3);
        delay_bus  = {16'(d3), 16'(d2), 16'(d1), 16'(d0)};
        delay_bus4 = {4'(d3), 4'(d2), 4'(d1), 4'(d0)};
    endtask

    task automatic do_reset(input string tag);
        in_valid = 1'b0;
        reset_n  = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        chk({tag, "_rdy_lo"}, 32'(in_ready), 32'd0);
        step();
        chk({tag, "_rdy_hi"}, 32'(in_ready), 32'd1);
    endtask

    // Offer one sample, wait for its result, check latency, value on both instances and the single pulse.
    task automatic send(input logic [15:0] s, input logic [15:0] wet, input string tag, output int rdy_low);
        int w;
        int lat;
        w = 0;
        while (!in_ready && w < 20) begin
            step();
            w++;
        end
        chk({tag, "_ready"}, 32'(in_ready), 32'd1);
        in_sample = s;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        lat      = 1;
        rdy_low  = 0;
        while (!out_valid && lat < 20) begin
            if (!in_ready) rdy_low++;
            step();
            lat++;
        end
        if (!in_ready) rdy_low++;
        chk({tag, "_lat"}, 32'(lat), 32'd6);
        chk({tag, "_out"}, 32'(out_sample), 32'(mix(s, wet)));
        chk({tag, "_vld4"}, 32'(out_valid4), 32'd1);
        chk({tag, "_out4"}, 32'(out_sample4), 32'(mix(s, wet)));
        step();
        chk({tag, "_pulse"}, 32'(out_valid), 32'd0);
        chk({tag, "_hold"}, 32'(out_sample), 32'(mix(s, wet)));
    endtask

    initial begin
        int rl;
        int n_out;
        logic [15:0] outs [0:3];
        logic seen;
        int wet;

        // Reset state and a single sample with zero delays.
        reset_n = 1'b0;
        set_delays(0, 0, 0, 0);
        step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sample", 32'(out_sample), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        do_reset("t1");
        send(16'h1000, 16'h1000, "t1", rl);
        chk("t1_ready_low_cycles", 32'(rl), 32'd6);

        // Ramp with staggered taps; early samples see gated voices.
        do_reset("t2");
        set_delays(0, 1, 2, 3);
        for (int k = 0; k < 10; k++) begin
            wet = (k < 3) ? 0 : (4 * k - 6) / 4;
            send(16'(k), 16'(wet), $sformatf("t2_k%0d", k), rl);
        end

        // Signed extremes and truncation toward -inf.
        do_reset("t4");
        set_delays(0, 0, 0, 0);
        send(16'h8000, 16'h8000, "t4_min", rl);
        send(16'hFFFF, 16'hFFFF, "t4_m1", rl);
        set_delays(1, 1, 1, 0);
        send(16'h0000, 16'hFFFF, "t4_m3", rl);
        set_delays(0, 1, 1, 1);
        send(16'h7FFF, 16'h1FFF, "t4_max", rl);

        // in_valid held high: accepted only every 7th cycle, drops never reach the RAM.
        do_reset("t5");
        set_delays(0, 0, 0, 0);
        n_out = 0;
        for (int i = 0; i < 14; i++) begin
            in_sample = 16'(100 + i);
            in_valid  = 1'b1;
            chk($sformatf("t5_ready_i%0d", i), 32'(in_ready), 32'((i % 7) == 0));
            step();
            if (out_valid && n_out < 4) begin
                outs[n_out] = out_sample;
                n_out++;
            end
        end
        in_valid = 1'b0;
        chk("t5_nout", 32'(n_out), 32'd2);
        chk("t5_out0", 32'(outs[0]), 32'(mix(16'd100, 16'd100)));
        chk("t5_out1", 32'(outs[1]), 32'(mix(16'd107, 16'd107)));
        chk("t5_overrun", 32'(overrun), 32'd1);
        set_delays(1, 1, 1, 1);
        send(16'h0055, 16'd107, "t5_nodrop", rl);

        // Reset while reading: outputs clear at once and the in-flight sample never emerges.
        set_delays(5, 5, 5, 5);
        in_sample = 16'h1234;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        reset_n = 1'b0;
        #1;
        chk("t6_out_valid", 32'(out_valid), 32'd0);
        chk("t6_out_sample", 32'(out_sample), 32'd0);
        chk("t6_overrun", 32'(overrun), 32'd0);
        chk("t6_in_ready", 32'(in_ready), 32'd0);
        step();
        step();
        reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            seen = seen | out_valid | out_valid4;
        end
        chk("t6_no_pulse", 32'(seen), 32'd0);
        send(16'h0777, 16'h0000, "t6_gated", rl);

        // Pointer wrap on the 16-deep instance; delay 15 at n=19 lands on the word written at n=4.
        do_reset("t3");
        set_delays(15, 15, 15, 15);
        for (int n = 0; n < 20; n++) begin
            wet = (n >= 15) ? n - 15 : 0;
            send(16'(n), 16'(wet), $sformatf("t3_n%0d", n), rl);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
